// File: rtl/uart_host_master.sv
// Host-side initiator for the regfile UART link: sends 18-bit write/read packets on posi and
// captures the read response on piso. Define UART_HOST_TIMEOUT_EN to bound the response wait.
module uart_host_master #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic       posi,
  input  logic       piso
);
  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]        BIT_LAST  = 5'd19;

  typedef enum logic [2:0] {IDLE, TX, WAIT_RSP, RX, DONE} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [4:0]        bit_q, bit_d;
  logic [17:0]       tx_pkt_q, tx_pkt_d;
  logic [17:0]       rx_pkt_q, rx_pkt_d;
  logic              stop_q, stop_d;
  logic              posi_q, posi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              piso_meta_q, piso_sync_q, piso_prev_q;

  logic              accept;
  logic              piso_fall;
  logic              baud_last;
  logic              frame_last;
  logic              timeout;
  logic [19:0]       tx_frame;
  logic [16:0]       tx_body;
  logic [1:0]        rx_err;

  assign accept     = cmd_valid & cmd_ready;
  assign piso_fall  = piso_prev_q & ~piso_sync_q;
  assign baud_last  = (baud_q == BAUD_LAST);
  assign frame_last = (bit_q == BIT_LAST) && baud_last;
  assign tx_frame   = {1'b1, tx_pkt_q, 1'b0};
  assign tx_body    = {cmd_addr, (cmd_write ? cmd_wdata : 8'h00), cmd_write};

  // Stop bit first, then overall odd parity, then address/direction of the reply.
  assign rx_err = !stop_q                                           ? 2'b10 :
                  !(^rx_pkt_q)                                      ? 2'b01 :
                  ((rx_pkt_q[16:9] != tx_pkt_q[16:9]) || rx_pkt_q[0]) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      piso_meta_q <= 1'b1;
      piso_sync_q <= 1'b1;
      piso_prev_q <= 1'b1;
    end else begin
      piso_meta_q <= piso;
      piso_sync_q <= piso_meta_q;
      piso_prev_q <= piso_sync_q;
    end
  end

`ifdef UART_HOST_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign timeout = (state_q == WAIT_RSP) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = 16'd0;
    if (state_q == WAIT_RSP && !piso_fall && !timeout) tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= 16'd0;
    else          tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = TX;
      TX:       if (frame_last) state_d = tx_pkt_q[0] ? IDLE : WAIT_RSP;
      WAIT_RSP: begin
        if (piso_fall)    state_d = RX;
        else if (timeout) state_d = IDLE;
      end
      RX: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (bit_q == 5'd0) begin
          if (baud_q == BAUD_HALF && piso_sync_q) state_d = WAIT_RSP;
        end else if (frame_last) begin
          state_d = DONE;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_d      = baud_q;
    bit_d       = bit_q;
    tx_pkt_d    = tx_pkt_q;
    rx_pkt_d    = rx_pkt_q;
    stop_d      = stop_q;
    posi_d      = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_pkt_d = {~^tx_body, tx_body};
          baud_d   = '0;
          bit_d    = 5'd0;
        end
      end
      TX: begin
        posi_d = tx_frame[bit_q];
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = 5'd0;
            if (tx_pkt_q[0]) begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = 8'h00;
              rsp_err_d   = 2'b00;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      WAIT_RSP: begin
        if (piso_fall) begin
          baud_d = '0;
          bit_d  = 5'd0;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 2'b11;
        end
      end
      RX: begin
        if (baud_q == ((bit_q == 5'd0) ? BAUD_HALF : BAUD_LAST)) begin
          baud_d = '0;
          if (bit_q == 5'd0) begin
            if (!piso_sync_q) bit_d = 5'd1;
          end else if (bit_q == BIT_LAST) begin
            stop_d = piso_sync_q;
            bit_d  = 5'd0;
          end else begin
            rx_pkt_d = {piso_sync_q, rx_pkt_q[17:1]};
            bit_d    = bit_q + 5'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rx_pkt_q[8:1];
        rsp_err_d   = rx_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q      <= '0;
      bit_q       <= 5'd0;
      tx_pkt_q    <= 18'd0;
      rx_pkt_q    <= 18'd0;
      stop_q      <= 1'b0;
      posi_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 2'b00;
    end else begin
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      tx_pkt_q    <= tx_pkt_d;
      rx_pkt_q    <= rx_pkt_d;
      stop_q      <= stop_d;
      posi_q      <= posi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The response cycle still counts as busy; the next command is taken one clk later.
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
  assign busy      = ~cmd_ready;
  assign posi      = posi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_host_master.sv
// Directed plus randomized bench for uart_host_master with a packet-level reference model.
// The timeout check is included when UART_HOST_TIMEOUT_EN is defined.
module tb_uart_host_master;
  localparam int CPB   = 16;
  localparam int TMO   = 4096;
  localparam int FRAME = 20 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       piso = 1'b1;
  logic       cmd_ready, rsp_valid, busy, posi;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_host_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .posi(posi), .piso(piso)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_pkt(input logic w, input logic [7:0] a, input logic [7:0] d);
    logic [16:0] body;
    body = {a, d, w};
    return {(($countones(body) % 2) == 0), body};
  endfunction

  function automatic logic [19:0] model_frame(input logic w, input logic [7:0] a, input logic [7:0] d);
    return {1'b1, model_pkt(w, a, w ? d : 8'h00), 1'b0};
  endfunction

  function automatic logic [1:0] model_err(input logic [17:0] pkt, input logic stop_b, input logic [7:0] a);
    if (!stop_b) return 2'b10;
    if (($countones(pkt) % 2) == 0) return 2'b01;
    if (pkt[16:9] != a || pkt[0]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic hold, output logic [19:0] obs_f);
    logic [19:0] exp_f;
    int          lat;
    logic        ready_at_rsp;
    logic [7:0]  rd;
    logic [1:0]  er;
    exp_f = model_frame(w, a, d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = hold; cmd_write = ~w; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    check("busy_accept", 32'(busy), 32'd1);
    obs_f = '0; lat = -1; ready_at_rsp = 1'b1; rd = 8'h00; er = 2'b00;
    for (int m = 1; m <= FRAME; m++) begin
      @(negedge clk);
      if ((m - 1) % CPB == CPB / 2) obs_f[(m - 1) / CPB] = posi;
      if (rsp_valid && lat < 0) begin
        lat = m; ready_at_rsp = cmd_ready; rd = rsp_rdata; er = rsp_err;
      end
    end
    cmd_valid = 1'b0;
    check("frame", 32'(obs_f), 32'(exp_f));
    if (w) begin
      check("wr_latency", 32'(lat), 32'(FRAME));
      check("wr_ready_in_rsp", 32'(ready_at_rsp), 32'd0);
      check("wr_rdata", 32'(rd), 32'h00);
      check("wr_err", 32'(er), 32'd0);
      @(negedge clk);
      check("ready_after_rsp", 32'(cmd_ready), 32'd1);
    end else begin
      check("rd_no_early_rsp", 32'(lat), 32'(-1));
    end
    $display("cmd w=%0d addr=%02h data=%02h frame=%05h", w, a, d, obs_f);
  endtask

  task automatic slave_reply(input logic [17:0] pkt, input logic stop_b, input logic [7:0] sent_a);
    logic [19:0] fr;
    int          nv;
    logic [7:0]  rd;
    logic [1:0]  er;
    fr = {stop_b, pkt, 1'b0};
    nv = 0; rd = 8'h00; er = 2'b00;
    for (int m = 0; m < FRAME + 40; m++) begin
      piso = (m < FRAME) ? fr[m / CPB] : 1'b1;
      @(negedge clk);
      if (rsp_valid) begin nv++; rd = rsp_rdata; er = rsp_err; end
    end
    piso = 1'b1;
    check("rsp_pulses", 32'(nv), 32'd1);
    check("rsp_rdata", 32'(rd), 32'(pkt[8:1]));
    check("rsp_err", 32'(er), 32'(model_err(pkt, stop_b, sent_a)));
    $display("rsp pkt=%05h stop=%0d rdata=%02h err=%0d", pkt, stop_b, rd, er);
  endtask

  // fault: 0 none, 1 parity flipped, 2 wrong address, 3 wrb set, 4 stop bit low
  task automatic read_txn(input logic [7:0] a, input logic [7:0] d, input int fault, input int dly);
    logic [17:0] pkt;
    logic        stop_b;
    logic [19:0] f;
    pkt = model_pkt(1'b0, a, d);
    stop_b = 1'b1;
    case (fault)
      1: pkt[17] = ~pkt[17];
      2: pkt = model_pkt(1'b0, a + 8'd1, d);
      3: pkt = model_pkt(1'b1, a, d);
      4: stop_b = 1'b0;
      default: ;
    endcase
    send_cmd(1'b0, a, 8'($urandom), 1'b0, f);
    repeat (dly) @(negedge clk);
    slave_reply(pkt, stop_b, a);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] f;
    int          nv;
    int          nlow;

    repeat (3) @(negedge clk);
    check("rst_posi", 32'(posi), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'h00);
    check("rst_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send_cmd(1'b1, 8'h12, 8'hA5, 1'b0, f);
    check("wr12_frame_const", 32'(f), 32'({1'b1, 1'b0, 8'h12, 8'hA5, 1'b1, 1'b0}));

    read_txn(8'h34, 8'h5A, 0, 5);
    read_txn(8'h34, 8'h5A, 1, 0);
    read_txn(8'h34, 8'h5A, 2, 3);
    read_txn(8'h34, 8'h5A, 4, 7);
    read_txn(8'h34, 8'h5A, 3, 1);

    // Short low pulse while waiting for the reply must not start reception.
    send_cmd(1'b0, 8'h34, 8'h00, 1'b0, f);
    piso = 1'b0;
    repeat (3) @(negedge clk);
    piso = 1'b1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    check("glitch_no_rsp", 32'(nv), 32'd0);
    check("glitch_busy", 32'(busy), 32'd1);
    slave_reply(model_pkt(1'b0, 8'h34, 8'hC3), 1'b1, 8'h34);

    // cmd_valid held through the whole transaction gives exactly one transaction.
    send_cmd(1'b1, 8'h5C, 8'h3E, 1'b1, f);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    check("hold_single_rsp", 32'(nv), 32'd0);
    check("hold_idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        send_cmd(1'b1, 8'($urandom), 8'($urandom), 1'b0, f);
      else
        read_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 30)));
    end

`ifdef UART_HOST_TIMEOUT_EN
    begin
      int         lat;
      logic [7:0] rd;
      logic [1:0] er;
      send_cmd(1'b0, 8'h77, 8'h00, 1'b0, f);
      lat = -1; rd = 8'hFF; er = 2'b00;
      for (int n = 1; n <= TMO + 50 && lat < 0; n++) begin
        @(negedge clk);
        if (rsp_valid) begin lat = n; rd = rsp_rdata; er = rsp_err; end
      end
      check("tmo_latency", 32'(lat), 32'(TMO));
      check("tmo_err", 32'(er), 32'd3);
      check("tmo_rdata", 32'(rd), 32'h00);
      $display("timeout rsp after %0d clks err=%0d", lat, er);
      @(negedge clk);
    end
`endif

    // Reset in the middle of the start bit aborts without a response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h42; cmd_wdata = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midtx_posi_low", 32'(posi), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_posi", 32'(posi), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nv = 0; nlow = 0;
    for (int i = 0; i < FRAME + 40; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
      if (!posi) nlow++;
    end
    check("abort_no_rsp", 32'(nv), 32'd0);
    check("abort_posi_idle", 32'(nlow), 32'd0);
    $display("reset abort rsp_pulses=%0d posi_low_clks=%0d", nv, nlow);

    send_cmd(1'b1, 8'hE7, 8'h18, 1'b0, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
